xlib_dma_rc_avm: RTL and testbench

Bus-side bridge directly downstream of the compact read DMA engine. It consumes the engine's per-beat burst request stream (biu_*) and issues one Avalon-MM burst read per burst. Returned read data goes into an internal data FIFO, and the bridge returns the response strobe and the reserved FIFO level to the engine. The FIFO's pop side feeds the stream consumer.

---
 rtl/xlib_dma_rc_avm_if.sv | 23 ++
 rtl/xlib_dma_rc_avm.sv | 122 ++++++++++++
 tb/tb_xlib_dma_rc_avm.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/xlib_dma_rc_avm_if.sv
// xlib_dma_rc_avm_if: Avalon-MM burst-read bus between the DMA bridge (master) and memory (slave).
interface xlib_dma_rc_avm_if #(
    parameter int AW = 32,
    parameter int BL = 4,
    parameter int DW = 32
);
    logic [AW-1:0] address;
    logic          read;
    logic [BL:0]   burstcount;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;

    modport master (
        output address, read, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/xlib_dma_rc_avm.sv
// xlib_dma_rc_avm: burst request stream to Avalon-MM burst reads, read data into a reserved FWFT FIFO.
// Optional XLIB_DMA_RC_AVM_PIPE_EN registers the Avalon read-data return before the FIFO.
module xlib_dma_rc_avm #(
    parameter int AL        = 2,
    parameter int AW        = 32,
    parameter int BL        = 4,
    parameter int FW        = 6,
    parameter int DW        = 32,
    parameter int BLEN_TYPE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          biu_adr,
    input  logic [BL-BLEN_TYPE:0]  biu_len,
    input  logic                   biu_sob,
    input  logic                   biu_eob,
    input  logic                   biu_val,
    output logic                   biu_rdy,
    output logic                   rsp_val,
    output logic [FW:0]            dff_cnt,
    xlib_dma_rc_avm_if.master      avm,
    output logic [DW-1:0]          dff_q,
    input  logic                   dff_rd,
    output logic                   dff_empty,
    output logic                   err
);
    typedef enum logic [1:0] {IDLE, CMD, CMD_LAST, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q;
    logic [BL:0]   bc_q, bc;
    logic [FW:0]   cnt_q, cnt_d, wp_q, rp_q, fill, outst;
    logic [DW-1:0] mem [2**FW];
    logic [DW-1:0] dat;
    logic          fits, acc, pop, push, full, dv, rd, err_q, err_d;

    assign bc   = (BL+1)'(biu_len) + (BL+1)'(BLEN_TYPE);
    assign fits = ({1'b0, cnt_q} + (FW+2)'(bc)) <= (FW+2)'(2**FW);
    assign acc  = (state_q == IDLE) & biu_val & biu_sob & fits;

    always_comb begin
        state_d = state_q;
        biu_rdy = 1'b0;
        rd      = 1'b0;
        case (state_q)
            IDLE: begin
                biu_rdy = biu_sob & fits;
                if (acc) state_d = biu_eob ? CMD_LAST : CMD;
            end
            CMD: begin
                rd = 1'b1;
                if (!avm.waitrequest) state_d = DRAIN;
            end
            CMD_LAST: begin
                rd = 1'b1;
                if (!avm.waitrequest) state_d = IDLE;
            end
            default: begin
                biu_rdy = 1'b1;
                if (biu_val & biu_eob) state_d = IDLE;
            end
        endcase
    end

`ifdef XLIB_DMA_RC_AVM_PIPE_EN
    logic          dv_q;
    logic [DW-1:0] dat_q;
    always_ff @(posedge clk) begin
        dv_q  <= !rst & avm.readdatavalid;
        dat_q <= avm.readdata;
    end
    assign dv  = dv_q;
    assign dat = dat_q;
`else
    assign dv  = avm.readdatavalid;
    assign dat = avm.readdata;
`endif

    // outstanding is reservation minus fill, so it returns to zero on reset with the rest
    assign fill      = wp_q - rp_q;
    assign outst     = cnt_q - fill;
    assign dff_empty = wp_q == rp_q;
    assign full      = (wp_q[FW] != rp_q[FW]) && (wp_q[FW-1:0] == rp_q[FW-1:0]);
    assign pop       = dff_rd & !dff_empty;
    assign rsp_val   = dv & |outst;
    assign push      = rsp_val & !full;
    assign cnt_d     = cnt_q + (acc ? (FW+1)'(bc) : '0) - (FW+1)'(pop);
    assign err_d     = err_q | (dv & ~|outst) | (rsp_val & full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            bc_q    <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                adr_q <= biu_adr;
                bc_q  <= bc;
            end
            cnt_q <= cnt_d;
            wp_q  <= wp_q + (FW+1)'(push);
            rp_q  <= rp_q + (FW+1)'(pop);
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q[FW-1:0]] <= dat;
    end

    assign dff_q          = mem[rp_q[FW-1:0]];
    assign dff_cnt        = cnt_q;
    assign err            = err_q;
    assign avm.read       = rd;
    assign avm.address    = adr_q & ~AW'(2**AL - 1);
    assign avm.burstcount = bc_q;
endmodule

// File: tb/tb_xlib_dma_rc_avm.sv
// tb_xlib_dma_rc_avm: directed checks of burst issue, reservation back-pressure, FIFO order and error handling.
module tb_xlib_dma_rc_avm;
`ifdef XLIB_DMA_RC_AVM_PIPE_EN
    localparam int PL = 1;
`else
    localparam int PL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] biu_adr = '0;
    logic [4:0]  biu_len = '0;
    logic [3:0]  len1 = '0;
    logic        biu_sob = 1'b0, biu_eob = 1'b0, biu_val = 1'b0, val1 = 1'b0;
    logic        wait_r = 1'b0, rdv = 1'b0, dff_rd = 1'b0;
    logic [31:0] rdata = '0;
    logic        biu_rdy, rsp_val, dff_empty, err;
    logic [6:0]  dff_cnt;
    logic [31:0] dff_q;
    logic        rdy1, rsp1, empty1, err1;
    logic [6:0]  cnt1;
    logic [31:0] q1;
    int          checks = 0, errors = 0, wk = 0, rk = 0, nr = 0;

    xlib_dma_rc_avm_if #(.AW(32), .BL(4), .DW(32)) a_if ();
    xlib_dma_rc_avm_if #(.AW(32), .BL(4), .DW(32)) b_if ();

    assign a_if.waitrequest   = wait_r;
    assign a_if.readdata      = rdata;
    assign a_if.readdatavalid = rdv;
    assign b_if.waitrequest   = 1'b0;
    assign b_if.readdata      = '0;
    assign b_if.readdatavalid = 1'b0;

    xlib_dma_rc_avm u0 (
        .clk(clk), .rst(rst), .biu_adr(biu_adr), .biu_len(biu_len), .biu_sob(biu_sob),
        .biu_eob(biu_eob), .biu_val(biu_val), .biu_rdy(biu_rdy), .rsp_val(rsp_val),
        .dff_cnt(dff_cnt), .avm(a_if), .dff_q(dff_q), .dff_rd(dff_rd),
        .dff_empty(dff_empty), .err(err)
    );

    xlib_dma_rc_avm #(.BLEN_TYPE(1)) u1 (
        .clk(clk), .rst(rst), .biu_adr(biu_adr), .biu_len(len1), .biu_sob(biu_sob),
        .biu_eob(biu_eob), .biu_val(val1), .biu_rdy(rdy1), .rsp_val(rsp1),
        .dff_cnt(cnt1), .avm(b_if), .dff_q(q1), .dff_rd(1'b0),
        .dff_empty(empty1), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int len);
        biu_val = 1'b1; biu_sob = 1'b1; biu_eob = 1'b1; biu_adr = 32'h2000; biu_len = 5'(len); wait_r = 1'b0;
        tick();
        biu_val = 1'b0; biu_sob = 1'b0; biu_eob = 1'b0;
        #1;
        chk("last_read", a_if.read, 1);
        chk("last_bc", a_if.burstcount, len);
        tick();
        chk("last_idle", a_if.read, 0);
    endtask

    task automatic ret(input int n);
        nr = 0;
        for (int i = 0; i < n; i++) begin
            rdv = 1'b1; rdata = 32'h100 + wk; wk++;
            #1 nr += int'(rsp_val);
            tick();
        end
        rdv = 1'b0;
        #1 nr += int'(rsp_val);
        tick();
        chk("rsp_count", nr, n);
    endtask

    task automatic pop(input int n);
        for (int i = 0; i < n; i++) begin
            dff_rd = 1'b1;
            #1 chk("pop_data", dff_q, 32'h100 + rk);
            rk++;
            tick();
        end
        dff_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_read", a_if.read, 0);
        chk("rst_addr", a_if.address, 0);
        chk("rst_bc", a_if.burstcount, 0);
        chk("rst_rsp", rsp_val, 0);
        chk("rst_cnt", dff_cnt, 0);
        chk("rst_empty", dff_empty, 1);
        chk("rst_err", err, 0);
        chk("rst_rdy", biu_rdy, 0);
        // count-1 length encoding
        val1 = 1'b1; biu_sob = 1'b1; biu_eob = 1'b1; len1 = 4'hF;
        #1 chk("axi_rdy", rdy1, 1);
        tick();
        val1 = 1'b0; biu_sob = 1'b0; biu_eob = 1'b0;
        chk("axi_bc", b_if.burstcount, 16);
        chk("axi_read", b_if.read, 1);
        // single 16-word burst with 3 wait cycles and 15 drain beats
        biu_val = 1'b1; biu_sob = 1'b1; biu_adr = 32'h1000; biu_len = 5'd16; wait_r = 1'b1;
        #1 chk("sob_rdy", biu_rdy, 1);
        tick();
        biu_sob = 1'b0;
        chk("sob_cnt", dff_cnt, 16);
        chk("sob_addr", a_if.address, 32'h1000);
        chk("sob_bc", a_if.burstcount, 16);
        for (int k = 0; k < 4; k++) begin
            wait_r = k < 3;
            #1 chk("cmd_read", a_if.read, 1);
            chk("cmd_rdy", biu_rdy, 0);
            tick();
        end
        for (int i = 0; i < 15; i++) begin
            biu_eob = i == 14;
            #1 chk("drain_rdy", biu_rdy, 1);
            tick();
        end
        biu_val = 1'b0; biu_eob = 1'b0;
        #1 chk("drain_done_read", a_if.read, 0);
        chk("drain_done_rdy", biu_rdy, 0);
        ret(16);
        chk("fill_empty", dff_empty, 0);
        chk("fill_cnt", dff_cnt, 16);
        pop(16);
        #1 chk("pop_cnt", dff_cnt, 0);
        chk("pop_empty", dff_empty, 1);
        // return latency
        burst(1);
        rdv = 1'b1; rdata = 32'h100 + wk; wk++;
        #1 chk("lat_rsp0", rsp_val, PL == 0);
        chk("lat_empty0", dff_empty, 1);
        tick();
        rdv = 1'b0;
        #1 chk("lat_rsp1", rsp_val, PL == 1);
        chk("lat_empty1", dff_empty, PL == 1);
        tick();
        chk("lat_empty2", dff_empty, 0);
        pop(1);
        // reservation back-pressure at 56 words held
        for (int b = 0; b < 3; b++) begin
            burst(16);
            ret(16);
        end
        burst(8);
        ret(8);
        chk("bp_cnt", dff_cnt, 56);
        biu_val = 1'b1; biu_sob = 1'b1; biu_eob = 1'b1; biu_len = 5'd16;
        #1 chk("bp_rdy_lo", biu_rdy, 0);
        tick();
        chk("bp_hold_cnt", dff_cnt, 56);
        for (int i = 0; i < 8; i++) begin
            dff_rd = 1'b1;
            #1 chk("bp_rdy_wait", biu_rdy, 0);
            chk("bp_pop_data", dff_q, 32'h100 + rk);
            rk++;
            tick();
        end
        dff_rd = 1'b0;
        #1 chk("bp_rdy_hi", biu_rdy, 1);
        biu_val = 1'b0; biu_sob = 1'b0; biu_eob = 1'b0;
        pop(38);
        #1 chk("pp_pre_cnt", dff_cnt, 10);
        // simultaneous push and pop at fill 10
        burst(8);
        chk("pp_res_cnt", dff_cnt, 18);
        for (int i = 0; i < 8; i++) begin
            rdv = 1'b1; rdata = 32'h100 + wk; wk++; dff_rd = 1'b1;
            #1 chk("pp_data", dff_q, 32'h100 + rk);
            rk++;
            tick();
            chk("pp_cnt", dff_cnt, 17 - i);
        end
        rdv = 1'b0; dff_rd = 1'b0;
        tick();
        chk("pp_post_cnt", dff_cnt, 10);
        pop(10);
        #1 chk("pp_empty", dff_empty, 1);
        chk("pp_cnt0", dff_cnt, 0);
        chk("pp_err", err, 0);
        // reset with 8 words outstanding
        burst(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_cnt", dff_cnt, 0);
        chk("mr_err0", err, 0);
        chk("mr_read", a_if.read, 0);
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            rdv = 1'b1; rdata = 32'hDEAD;
            #1 nr += int'(rsp_val);
            tick();
        end
        rdv = 1'b0;
        #1 nr += int'(rsp_val);
        tick();
        chk("mr_rsp", nr, 0);
        chk("mr_empty", dff_empty, 1);
        chk("mr_err1", err, 1);
        repeat (3) tick();
        chk("mr_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_clear", err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
